// File: rtl/move_cmd_gen_pkg.sv
// Shared types and constants for the move command generator: FSM states,
// one-hot direction codes in {Rt,Lt,Dn,Up} order, and a set-bit counter.
package move_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        REPEAT,
        BLOCKED,
        ACTIVE
    } state_t;

    localparam logic [3:0] DIR_UP = 4'b0001;
    localparam logic [3:0] DIR_DN = 4'b0010;
    localparam logic [3:0] DIR_LT = 4'b0100;
    localparam logic [3:0] DIR_RT = 4'b1000;

    localparam int unsigned IDX_UP = 0;
    localparam int unsigned IDX_DN = 1;
    localparam int unsigned IDX_LT = 2;
    localparam int unsigned IDX_RT = 3;

    function automatic logic [2:0] f_count_set(input logic [3:0] i_Vec);
        logic [2:0] v_Count;
        v_Count = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            v_Count = v_Count + {2'b00, i_Vec[i]};
        end
        return v_Count;
    endfunction

endpackage

// File: rtl/move_cmd_gen_btn_debounce.sv
// One button: 2-FF synchroniser followed by a stability counter that flips
// the debounced level after c_DEBOUNCE_LIMIT consecutive disagreeing cycles.
module btn_debounce #(
    parameter int unsigned c_DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Btn,
    output logic o_State
);

    localparam int unsigned c_CNT_W = (c_DEBOUNCE_LIMIT > 1) ? $clog2(c_DEBOUNCE_LIMIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DEBOUNCE_LIMIT - 1);

    logic               r_Sync1;
    logic               r_Sync2;
    logic               r_State;
    logic [c_CNT_W-1:0] r_Count;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Sync1 <= 1'b0;
            r_Sync2 <= 1'b0;
            r_State <= 1'b0;
            r_Count <= '0;
        end else begin
            r_Sync1 <= i_Btn;
            r_Sync2 <= r_Sync1;
            if (r_Sync2 == r_State) begin
                r_Count <= '0;
            end else if (r_Count == c_CNT_LAST) begin
                r_State <= ~r_State;
                r_Count <= '0;
            end else begin
                r_Count <= r_Count + 1'b1;
            end
        end
    end

    assign o_State = r_State;

endmodule

// File: rtl/move_cmd_gen.sv
// Debounces four direction buttons and arbitrates them into one-hot step strobes.
// Define MOVE_AUTO_REPEAT_EN for timed auto-repeat; otherwise one strobe per press.
import move_pkg::*;

module move_cmd_gen #(
    parameter int unsigned c_DEBOUNCE_LIMIT = 250000,
    parameter int unsigned c_REPEAT_DELAY   = 12500000,
    parameter int unsigned c_REPEAT_RATE    = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Btn_Up,
    input  logic       i_Btn_Dn,
    input  logic       i_Btn_Lt,
    input  logic       i_Btn_Rt,
    output logic [3:0] o_Step,
    output logic [3:0] o_Held,
    output logic       o_Blocked
);

    if (c_DEBOUNCE_LIMIT == 0 || c_REPEAT_DELAY == 0 || c_REPEAT_RATE == 0) begin : g_bad_param
        $error("move_cmd_gen: debounce and repeat periods must be non-zero");
    end

    logic [3:0] w_Raw;
    logic [3:0] w_Held;
    logic [2:0] w_Count;

    assign w_Raw = {i_Btn_Rt, i_Btn_Lt, i_Btn_Dn, i_Btn_Up};

    for (genvar g = 0; g < 4; g++) begin : g_deb
        btn_debounce #(
            .c_DEBOUNCE_LIMIT(c_DEBOUNCE_LIMIT)
        ) u_deb (
            .i_Clk  (i_Clk),
            .i_Rst  (i_Rst),
            .i_Btn  (w_Raw[g]),
            .o_State(w_Held[g])
        );
    end

    assign w_Count = f_count_set(w_Held);

    state_t     r_State;
    logic [3:0] r_Dir;
    logic [3:0] r_Step;
    logic       r_Blocked;

`ifdef MOVE_AUTO_REPEAT_EN
    localparam int unsigned c_TIMER_MAX = (c_REPEAT_DELAY > c_REPEAT_RATE) ? c_REPEAT_DELAY : c_REPEAT_RATE;
    localparam int unsigned c_TIMER_W   = (c_TIMER_MAX > 1) ? $clog2(c_TIMER_MAX) : 1;
    localparam logic [c_TIMER_W-1:0] c_DELAY_LAST = c_TIMER_W'(c_REPEAT_DELAY - 1);
    localparam logic [c_TIMER_W-1:0] c_RATE_LAST  = c_TIMER_W'(c_REPEAT_RATE - 1);

    logic [c_TIMER_W-1:0] r_Timer;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State   <= IDLE;
            r_Dir     <= '0;
            r_Step    <= '0;
            r_Blocked <= 1'b0;
`ifdef MOVE_AUTO_REPEAT_EN
            r_Timer   <= '0;
`endif
        end else begin
            r_Step <= '0;
            case (r_State)
                IDLE: begin
                    if (w_Count == 3'd1) begin
                        r_Dir  <= w_Held;
                        r_Step <= w_Held;
`ifdef MOVE_AUTO_REPEAT_EN
                        r_State <= DELAY;
                        r_Timer <= '0;
`else
                        r_State <= ACTIVE;
`endif
                    end else if (w_Count > 3'd1) begin
                        r_State   <= BLOCKED;
                        r_Blocked <= 1'b1;
                    end
                end
`ifdef MOVE_AUTO_REPEAT_EN
                // DELAY and REPEAT differ only in the period that ends the wait.
                DELAY, REPEAT: begin
                    if (w_Held == r_Dir) begin
                        if ((r_State == DELAY) ? (r_Timer == c_DELAY_LAST) : (r_Timer == c_RATE_LAST)) begin
                            r_Step  <= r_Dir;
                            r_Timer <= '0;
                            r_State <= REPEAT;
                        end else if (r_Timer != '1) begin
                            r_Timer <= r_Timer + 1'b1;
                        end
                    end else if (w_Held == '0) begin
                        r_State <= IDLE;
                    end else begin
                        r_State   <= BLOCKED;
                        r_Blocked <= 1'b1;
                    end
                end
`else
                ACTIVE: begin
                    if (w_Held == '0) begin
                        r_State <= IDLE;
                    end else if (w_Held != r_Dir) begin
                        r_State   <= BLOCKED;
                        r_Blocked <= 1'b1;
                    end
                end
`endif
                BLOCKED: begin
                    if (w_Held == '0) begin
                        r_State   <= IDLE;
                        r_Blocked <= 1'b0;
                    end
                end
                default: begin
                    r_State   <= IDLE;
                    r_Blocked <= 1'b0;
                end
            endcase
        end
    end

    assign o_Step    = r_Step;
    assign o_Held    = w_Held;
    assign o_Blocked = r_Blocked;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Directed bench for move_cmd_gen with short debounce/repeat periods; expectations
// follow MOVE_AUTO_REPEAT_EN so the same bench covers both builds.
import move_pkg::*;

module tb_move_cmd_gen;

`ifdef MOVE_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       up;
    logic       dn;
    logic       lt;
    logic       rt;
    logic [3:0] step;
    logic [3:0] held;
    logic       blocked;

    int total;
    int bad;

    move_cmd_gen #(
        .c_DEBOUNCE_LIMIT(4),
        .c_REPEAT_DELAY  (20),
        .c_REPEAT_RATE   (8)
    ) dut (
        .i_Clk    (clk),
        .i_Rst    (rst),
        .i_Btn_Up (up),
        .i_Btn_Dn (dn),
        .i_Btn_Lt (lt),
        .i_Btn_Rt (rt),
        .o_Step   (step),
        .o_Held   (held),
        .o_Blocked(blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after an edge; outputs are read 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        up = 1'b0; dn = 1'b0; lt = 1'b0; rt = 1'b0;
        tick();
        tick();
        total++; if (step !== 4'b0000) begin bad++; $display("FAIL reset_step got=%b exp=0000", step); end
        total++; if (held !== 4'b0000) begin bad++; $display("FAIL reset_held got=%b exp=0000", held); end
        total++; if (blocked !== 1'b0) begin bad++; $display("FAIL reset_blocked got=%b exp=0", blocked); end
        rst = 1'b0;
    endtask

    task automatic test_press_repeat();
        logic [3:0] eh, es;
        up = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            if (k == 61) up = 1'b0;
            tick();
            eh = (k >= 6 && k <= 65) ? DIR_UP : 4'b0000;
            es = (k == 7 || (REP && k >= 27 && k <= 66 && (k - 27) % 8 == 0)) ? DIR_UP : 4'b0000;
            total++; if (held !== eh) begin bad++; $display("FAIL press_held k=%0d got=%b exp=%b", k, held, eh); end
            total++; if (step !== es) begin bad++; $display("FAIL press_step k=%0d got=%b exp=%b", k, step, es); end
            total++; if (blocked !== 1'b0) begin bad++; $display("FAIL press_blocked k=%0d got=%b exp=0", k, blocked); end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] eh, es;
        for (int k = 1; k <= 50; k++) begin
            if (k <= 20) lt = (((k - 1) >> 1) % 2 == 0);
            else         lt = (k <= 40);
            tick();
            eh = (k >= 26 && k <= 45) ? DIR_LT : 4'b0000;
            es = (k == 27) ? DIR_LT : 4'b0000;
            total++; if (held !== eh) begin bad++; $display("FAIL bounce_held k=%0d got=%b exp=%b", k, held, eh); end
            total++; if (step !== es) begin bad++; $display("FAIL bounce_step k=%0d got=%b exp=%b", k, step, es); end
        end
    endtask

    task automatic test_blocked();
        logic [3:0] eh, es;
        logic       eb;
        for (int k = 1; k <= 55; k++) begin
            up = (k <= 45);
            rt = (k >= 11 && k <= 30);
            tick();
            eh = {(k >= 16 && k <= 35), 2'b00, (k >= 6 && k <= 50)};
            es = (k == 7) ? DIR_UP : 4'b0000;
            eb = (k >= 17 && k <= 51);
            total++; if (held !== eh) begin bad++; $display("FAIL blocked_held k=%0d got=%b exp=%b", k, held, eh); end
            total++; if (step !== es) begin bad++; $display("FAIL blocked_step k=%0d got=%b exp=%b", k, step, es); end
            total++; if (blocked !== eb) begin bad++; $display("FAIL blocked_flag k=%0d got=%b exp=%b", k, blocked, eb); end
        end
    endtask

    task automatic test_repress();
        logic [3:0] eh, es;
        for (int k = 1; k <= 40; k++) begin
            dn = (k <= 8) || (k >= 17 && k <= 29);
            tick();
            eh = ((k >= 6 && k <= 13) || (k >= 22 && k <= 34)) ? DIR_DN : 4'b0000;
            es = (k == 7 || k == 23) ? DIR_DN : 4'b0000;
            total++; if (held !== eh) begin bad++; $display("FAIL repress_held k=%0d got=%b exp=%b", k, held, eh); end
            total++; if (step !== es) begin bad++; $display("FAIL repress_step k=%0d got=%b exp=%b", k, step, es); end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] eh, es;
        for (int k = 1; k <= 60; k++) begin
            up  = (k <= 50);
            rst = (k == 30);
            tick();
            eh = ((k >= 6 && k <= 29) || (k >= 36 && k <= 55)) ? DIR_UP : 4'b0000;
            es = (k == 7 || k == 37 || (REP && k == 27)) ? DIR_UP : 4'b0000;
            total++; if (held !== eh) begin bad++; $display("FAIL rsthold_held k=%0d got=%b exp=%b", k, held, eh); end
            total++; if (step !== es) begin bad++; $display("FAIL rsthold_step k=%0d got=%b exp=%b", k, step, es); end
            total++; if (blocked !== 1'b0) begin bad++; $display("FAIL rsthold_blocked k=%0d got=%b exp=0", k, blocked); end
        end
        rst = 1'b0;
    endtask

    task automatic test_long_hold();
        logic [3:0] eh, es;
        int         n_strobe;
        int         exp_n;
        n_strobe = 0;
        exp_n    = REP ? 11 : 1;
        for (int k = 1; k <= 110; k++) begin
            rt = (k <= 100);
            tick();
            eh = (k >= 6 && k <= 105) ? DIR_RT : 4'b0000;
            es = (k == 7 || (REP && k >= 27 && k <= 106 && (k - 27) % 8 == 0)) ? DIR_RT : 4'b0000;
            if (step == DIR_RT) n_strobe++;
            total++; if (held !== eh) begin bad++; $display("FAIL long_held k=%0d got=%b exp=%b", k, held, eh); end
            total++; if (step !== es) begin bad++; $display("FAIL long_step k=%0d got=%b exp=%b", k, step, es); end
        end
        total++; if (n_strobe !== exp_n) begin bad++; $display("FAIL long_count got=%0d exp=%0d", n_strobe, exp_n); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] eh;
        logic       eb;
        for (int k = 1; k <= 22; k++) begin
            up = (k <= 11);
            dn = (k <= 11);
            tick();
            eh = (k >= 6 && k <= 16) ? 4'b0011 : 4'b0000;
            eb = (k >= 7 && k <= 17);
            total++; if (held !== eh) begin bad++; $display("FAIL simul_held k=%0d got=%b exp=%b", k, held, eh); end
            total++; if (step !== 4'b0000) begin bad++; $display("FAIL simul_step k=%0d got=%b exp=0000", k, step); end
            total++; if (blocked !== eb) begin bad++; $display("FAIL simul_blocked k=%0d got=%b exp=%b", k, blocked, eb); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_press_repeat();
        test_bounce();
        test_blocked();
        test_repress();
        test_reset_mid_hold();
        test_long_hold();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
